// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row/clear inputs and column drive, key event and
// digit-accumulator outputs.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        valid;
    logic        held;
    logic [31:0] val;
    logic [7:0]  en;

    modport master (
        output row, clr,
        input  col, key, valid, held, val, en
    );

    modport slave (
        input  row, clr,
        output col, key, valid, held, val, en
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column walk, ghost-rejecting full-scan decode,
// scan-level debounce and hex-digit accumulation for the seven-segment path.
module keypad_scanner #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 4
) (
    input  logic            kpd_clk,
    input  logic            kpd_rst,
    keypad_scanner_if.slave keypad_scanner_port
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_SCANS);

    // Indexed by {row, column}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    typedef enum logic {IDLE, PRESSED} state_t;

    state_t           state;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [1:0]       scan_n;
    logic [3:0]       scan_code;
    logic [1:0]       prev_n;
    logic [3:0]       prev_code;
    logic [CNT_W-1:0] stable_cnt;
    logic [3:0]       col_r;
    logic [3:0]       key_r;
    logic             valid_r;
    logic             held_r;
    logic [31:0]      val_r;
    logic [7:0]       en_r;

    logic [2:0]       col_n;
    logic [3:0]       col_code;
    logic             found;
    logic [2:0]       sum;
    logic [1:0]       merged_n;
    logic [3:0]       merged_code;
    logic [3:0]       res_code;
    logic [CNT_W-1:0] next_cnt;
    logic             sample;
    logic             scan_end;
    logic             stable;
    logic             press;
    logic             rel;

    // Key count per scan is tracked as 0, 1 or "many" so that a multi-key result
    // can be told apart from a release when deciding PRESSED -> IDLE.
    always_comb begin
        col_n    = '0;
        col_code = '0;
        found    = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_n = col_n + 3'd1;
                if (!found) begin
                    col_code = KEY_MAP[{2'(r), idx}];
                    found    = 1'b1;
                end
            end
        end
        sum         = 3'(scan_n) + col_n;
        merged_n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        merged_code = (scan_n == 2'd0) ? col_code : scan_code;
        res_code    = (merged_n == 2'd1) ? merged_code : 4'h0;
        if ((merged_n == prev_n) && (res_code == prev_code))
            next_cnt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
        else
            next_cnt = CNT_W'(1);
        sample   = (div == DIV_LAST);
        scan_end = sample && (idx == 2'd3);
        stable   = scan_end && (next_cnt == CNT_MAX);
        press    = stable && (state == IDLE) && (merged_n == 2'd1);
        rel      = stable && (state == PRESSED) && (merged_n == 2'd0);
    end

    always_ff @(posedge kpd_clk) begin
        if (kpd_rst) begin
            state      <= IDLE;
            row_meta   <= '1;
            row_sync   <= '1;
            div        <= '0;
            idx        <= '0;
            scan_n     <= '0;
            scan_code  <= '0;
            prev_n     <= '0;
            prev_code  <= '0;
            stable_cnt <= '0;
            col_r      <= 4'b1110;
            key_r      <= '0;
            valid_r    <= 1'b0;
            held_r     <= 1'b0;
            val_r      <= '0;
            en_r       <= '0;
        end else begin
            row_meta <= keypad_scanner_port.row;
            row_sync <= row_meta;
            valid_r  <= 1'b0;

            if (sample) begin
                div   <= '0;
                idx   <= idx + 2'd1;
                col_r <= ~(4'b0001 << (idx + 2'd1));
                if (scan_end) begin
                    scan_n     <= '0;
                    scan_code  <= '0;
                    prev_n     <= merged_n;
                    prev_code  <= res_code;
                    stable_cnt <= next_cnt;
                end else begin
                    scan_n    <= merged_n;
                    scan_code <= merged_code;
                end
            end else begin
                div <= div + DIV_W'(1);
            end

            // A clear coinciding with a press empties the history before the new digit enters.
            if (press) begin
                state   <= PRESSED;
                held_r  <= 1'b1;
                valid_r <= 1'b1;
                key_r   <= res_code;
                val_r   <= {(keypad_scanner_port.clr ? 28'h0 : val_r[27:0]), res_code};
                en_r    <= {(keypad_scanner_port.clr ? 7'h0 : en_r[6:0]), 1'b1};
            end else if (keypad_scanner_port.clr) begin
                val_r <= '0;
                en_r  <= '0;
            end

            if (rel) begin
                state  <= IDLE;
                held_r <= 1'b0;
            end
        end
    end

    assign keypad_scanner_port.col   = col_r;
    assign keypad_scanner_port.key   = key_r;
    assign keypad_scanner_port.valid = valid_r;
    assign keypad_scanner_port.held  = held_r;
    assign keypad_scanner_port.val   = val_r;
    assign keypad_scanner_port.en    = en_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed vector table plus randomized scan-level
// key patterns checked against a per-scan reference model.
module tb_keypad_scanner;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;
    localparam int SCAN_CYC  = 4 * SCAN_DIV;

    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    typedef struct {
        bit          rst_first;
        logic [15:0] mask;
        int          scans;
        int          clr_at;
        int          pulses;
        logic [3:0]  key;
        logic        held;
        logic [31:0] val;
        logic [7:0]  en;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] mask;
    int          n_pass;
    int          n_total;
    int          obs_pulses;

    int          m_cls;
    logic [3:0]  m_code;
    int          m_cnt;
    bit          m_held;
    bit          m_valid;
    logic [3:0]  m_key;
    logic [31:0] m_val;
    logic [7:0]  m_en;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .kpd_clk             (clk),
        .kpd_rst             (rst),
        .keypad_scanner_port (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to a driven-low column.
    always_comb begin
        kif.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4 + c] && !kif.col[c]) kif.row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cls = 0; m_code = 4'h0; m_cnt = 0; m_held = 0; m_valid = 0;
        m_key = 4'h0; m_val = '0; m_en = '0;
    endtask

    task automatic model_scan(input logic [15:0] m, input bit clr_hit);
        int n;
        logic [3:0] code;
        n = $countones(m);
        if (n > 2) n = 2;
        code = 4'h0;
        if (n == 1)
            for (int i = 0; i < 16; i++) if (m[i]) code = KEYMAP[i];
        if (clr_hit) begin m_val = '0; m_en = '0; end
        if (n == m_cls && code == m_code) m_cnt = (m_cnt < DEB_SCANS) ? m_cnt + 1 : DEB_SCANS;
        else m_cnt = 1;
        m_cls = n; m_code = code; m_valid = 0;
        if (m_cnt == DEB_SCANS) begin
            if (!m_held && n == 1) begin
                m_valid = 1; m_held = 1; m_key = code;
                m_val = {m_val[27:0], code};
                m_en  = {m_en[6:0], 1'b1};
            end else if (m_held && n == 0) begin
                m_held = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_col", 32'(kif.col), 32'h0000000E);
            check("rst_key", 32'(kif.key), 32'h0);
            check("rst_valid", 32'(kif.valid), 32'h0);
            check("rst_held", 32'(kif.held), 32'h0);
            check("rst_val", kif.val, 32'h0);
            check("rst_en", 32'(kif.en), 32'h0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // Starts 1ns after the edge that begins column 0; ends likewise one scan later.
    task automatic run_scan(input logic [15:0] m, input int clr_at);
        logic [3:0] exp_col;
        mask = m;
        for (int k = 1; k <= SCAN_CYC; k++) begin
            if (k == clr_at) kif.clr = 1'b1;
            @(posedge clk); #1;
            kif.clr = 1'b0;
            if (kif.valid === 1'b1) obs_pulses++;
            exp_col = ~(4'b0001 << ((k % SCAN_CYC) / SCAN_DIV));
            check("col", 32'(kif.col), 32'(exp_col));
            if (k < SCAN_CYC) check("valid_mid", 32'(kif.valid), 32'h0);
        end
        model_scan(m, clr_at != 0);
        check("m_valid", 32'(kif.valid), 32'(m_valid));
        check("m_key", 32'(kif.key), 32'(m_key));
        check("m_held", 32'(kif.held), 32'(m_held));
        check("m_val", kif.val, m_val);
        check("m_en", 32'(kif.en), 32'(m_en));
    endtask

    function automatic vec_t mk(bit r, logic [15:0] m, int s, int c, int p,
                                logic [3:0] k, logic h, logic [31:0] v, logic [7:0] e);
        vec_t t;
        t.rst_first = r; t.mask = m; t.scans = s; t.clr_at = c; t.pulses = p;
        t.key = k; t.held = h; t.val = v; t.en = e;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic [15:0] m;
        int p0, a, b, sel, nscan, ca;

        n_pass = 0; n_total = 0; obs_pulses = 0;
        rst = 1'b1; kif.clr = 1'b0; mask = '0;
        model_reset();

        vecs.push_back(mk(1, 16'h0000, 3, 0, 0, 4'h0, 0, 32'h0, 8'h00));
        vecs.push_back(mk(0, 16'h0020, 10, 0, 1, 4'h5, 1, 32'h5, 8'h01));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4'h5, 1, 32'h5, 8'h01));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4'h5, 0, 32'h5, 8'h01));
        vecs.push_back(mk(0, 16'h0001, 2, 0, 1, 4'h1, 1, 32'h51, 8'h03));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h1, 0, 32'h51, 8'h03));
        vecs.push_back(mk(0, 16'h0002, 2, 0, 1, 4'h2, 1, 32'h512, 8'h07));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h2, 0, 32'h512, 8'h07));
        vecs.push_back(mk(0, 16'h0004, 2, 0, 1, 4'h3, 1, 32'h5123, 8'h0F));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h3, 0, 32'h5123, 8'h0F));
        vecs.push_back(mk(0, 16'h0010, 2, 0, 1, 4'h4, 1, 32'h51234, 8'h1F));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h4, 0, 32'h51234, 8'h1F));
        vecs.push_back(mk(0, 16'h0020, 2, 0, 1, 4'h5, 1, 32'h512345, 8'h3F));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h5, 0, 32'h512345, 8'h3F));
        vecs.push_back(mk(0, 16'h0040, 2, 0, 1, 4'h6, 1, 32'h5123456, 8'h7F));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h6, 0, 32'h5123456, 8'h7F));
        vecs.push_back(mk(0, 16'h0100, 2, 0, 1, 4'h7, 1, 32'h51234567, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h7, 0, 32'h51234567, 8'hFF));
        vecs.push_back(mk(0, 16'h0200, 2, 0, 1, 4'h8, 1, 32'h12345678, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h8, 0, 32'h12345678, 8'hFF));
        vecs.push_back(mk(0, 16'h0400, 2, 0, 1, 4'h9, 1, 32'h23456789, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h9, 0, 32'h23456789, 8'hFF));
        vecs.push_back(mk(0, 16'h0008, 1, 0, 0, 4'h9, 0, 32'h23456789, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h9, 0, 32'h23456789, 8'hFF));
        vecs.push_back(mk(0, 16'h0003, 10, 0, 0, 4'h9, 0, 32'h23456789, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'h9, 0, 32'h23456789, 8'hFF));
        vecs.push_back(mk(0, 16'h8000, 3, 0, 1, 4'hD, 1, 32'h3456789D, 8'hFF));
        vecs.push_back(mk(0, 16'hC000, 3, 0, 0, 4'hD, 1, 32'h3456789D, 8'hFF));
        vecs.push_back(mk(0, 16'h4000, 3, 0, 0, 4'hD, 1, 32'h3456789D, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'hD, 0, 32'h3456789D, 8'hFF));
        vecs.push_back(mk(0, 16'h4000, 2, 0, 1, 4'hE, 1, 32'h456789DE, 8'hFF));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'hE, 0, 32'h456789DE, 8'hFF));
        vecs.push_back(mk(0, 16'h0800, 2, 0, 1, 4'hC, 1, 32'h56789DEC, 8'hFF));
        vecs.push_back(mk(0, 16'h0800, 2, 5, 0, 4'hC, 1, 32'h0, 8'h00));
        vecs.push_back(mk(1, 16'h0800, 2, 0, 1, 4'hC, 1, 32'hC, 8'h01));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'hC, 0, 32'hC, 8'h01));
        vecs.push_back(mk(0, 16'h2000, 2, 16, 1, 4'hF, 1, 32'hF, 8'h01));
        vecs.push_back(mk(0, 16'h0000, 2, 0, 0, 4'hF, 0, 32'hF, 8'h01));

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            p0 = obs_pulses;
            for (int s = 0; s < vecs[i].scans; s++)
                run_scan(vecs[i].mask, (s == vecs[i].scans - 1) ? vecs[i].clr_at : 0);
            check("vec_pulses", 32'(obs_pulses - p0), 32'(vecs[i].pulses));
            check("vec_key", 32'(kif.key), 32'(vecs[i].key));
            check("vec_held", 32'(kif.held), 32'(vecs[i].held));
            check("vec_val", kif.val, vecs[i].val);
            check("vec_en", 32'(kif.en), 32'(vecs[i].en));
        end

        for (int run = 0; run < 40; run++) begin
            sel = int'($urandom_range(9, 0));
            a   = int'($urandom_range(15, 0));
            b   = (a + int'($urandom_range(15, 1))) % 16;
            if (sel < 4)      m = 16'h0000;
            else if (sel < 8) m = 16'h0001 << a;
            else              m = (16'h0001 << a) | (16'h0001 << b);
            nscan = int'($urandom_range(4, 1));
            for (int s = 0; s < nscan; s++) begin
                ca = ($urandom_range(4, 0) == 0) ? int'($urandom_range(16, 1)) : 0;
                run_scan(m, ca);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display path. Scans a 4x4 matrix keypad (Pmod KYPD layout) by walking one active-low column at a time and reading the active-low rows.
- Debounces the scan result and emits a one-cycle key event.
- Accumulates entered hex digits into a 32-bit shift value plus an 8-bit digit-enable mask. These feed the display driver's data and enable inputs directly.

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven (dwell); minimum 4.
- DEB_SCANS, 4, consecutive identical full-scan results required to accept a press or a release; minimum 1.

Ports:
- kpd_clk  in  1  system clock
- kpd_rst  in  1  synchronous, active-high reset
- keypad_scanner_port_row  in  4  keypad rows, active-low, externally pulled up, asynchronous
- keypad_scanner_port_clr  in  1  synchronous clear of accumulated value and enable mask
- keypad_scanner_port_col  out  4  column drive, active-low, exactly one bit low at a time
- keypad_scanner_port_key  out  4  hex code of last accepted key
- keypad_scanner_port_valid  out  1  one-cycle pulse per accepted press
- keypad_scanner_port_held  out  1  high while an accepted key remains pressed
- keypad_scanner_port_val  out  32  digit history; newest digit in [3:0]
- keypad_scanner_port_en  out  8  digit-enable mask; one bit per entered digit, LSB first

Behaviour:
- Reset values:
  - col=4'b1110, key=0, valid=0, held=0, val=0, en=0.
  - FSM=IDLE, divider=0, column index=0, stable count=0, row synchronizer=4'b1111.
- Row synchronizer: 2-flop on row; all sampling uses the synchronized value.
- Column walk:
  - Divider counts 0..SCAN_DIV-1.
  - On divider==SCAN_DIV-1, rows are sampled for the current column, then the column index increments mod 4.
  - col = ~(4'b0001 << index).
- Key map, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan result:
  - A full scan is columns 0..3.
  - Result is hit=1 with code only if exactly one key was seen low across the whole scan.
  - Zero keys or two or more keys (ghost reject) give hit=0.
  - Result is finalized at the column-3 sample.
- Debounce:
  - At each scan end, if result equals the previous result, stable count increments, saturating at DEB_SCANS. Otherwise stable count is set to 1.
  - The result is "stable" on the scan where the count reaches DEB_SCANS.
- FSM IDLE -> PRESSED: stable hit. In the following cycle:
  - valid=1 for exactly one cycle, key<=code.
  - val<={val[27:0],code}.
  - en<={en[6:0],1'b1}, so en saturates at 8'hFF; after 8 digits the oldest digit shifts out.
- FSM PRESSED -> IDLE: stable no-hit.
- While PRESSED, a stable different key or a multi-key result causes no event. A new press requires a release through IDLE.
- held=1 exactly while in PRESSED.
- Latency: valid occurs 1 cycle after the scan end that completes the DEB_SCANS-th matching scan. Worst case press-to-valid is (DEB_SCANS+1)*4*SCAN_DIV+3 cycles.
- clr:
  - Sets val=0 and en=0; key, held and FSM are unaffected.
  - If clr coincides with a press event, clear is applied first: val=32'h0000000_code, en=8'h01.
- Reset mid-press:
  - All state returns to reset values.
  - A key still held after reset is re-debounced and produces a fresh valid.
- valid never asserts during reset or in the cycle reset deasserts.

Test Plan:
Bench uses SCAN_DIV=4 and DEB_SCANS=2, with a keypad model driving row[r]=0 when key(r,c) is pressed and col[c]==0.
1. Reset, then idle -> col sequence 1110,1101,1011,0111 repeating, 4 cycles each; val=0, en=0, valid never 1.
2. Press '5' (r1,c1) for 10 scans, then release -> exactly one valid pulse; key=4'h5, val=32'h00000005, en=8'h01. held=1 from the pulse until 2 clean scans after release.
3. Enter 1,2,3,4,5,6,7,8,9 with full releases between -> nine pulses; final val=32'h23456789, en=8'hFF.
4. Press 'A' for one scan only (bounce), and separately press '1' and '2' together for 10 scans -> no valid, held stays 0.
5. Hold 'D', then press 'E' additionally, then release 'D' while keeping 'E' -> one pulse (key=D) only. Releasing 'E' then re-pressing 'E' -> second pulse, key=E.
6. clr while 'C' is held -> val=0, en=0, held stays 1. Assert kpd_rst mid-press -> outputs return to reset values; after reset with 'C' still held -> new pulse, val=32'h0000000C, en=8'h01.
